// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants, header type and helpers for the deflection router
package router_pkg;

  localparam int ADDR_W    = 6;
  localparam int NUM_PORTS = 4;
  localparam int PORT_N    = 0;
  localparam int PORT_S    = 1;
  localparam int PORT_E    = 2;
  localparam int PORT_W    = 3;

  // Width-independent part of a flit; modules wrap it with their own payload width.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } flit_hdr_t;

  function automatic logic flit_valid(input flit_hdr_t hdr);
    return hdr.valid;
  endfunction

endpackage

// File: rtl/eject_fifo.sv
// rtl/eject_fifo.sv - synchronous FIFO with occupancy count and registered-state head
module eject_fifo #(
  parameter int W     = 22,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [W-1:0]             head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem[rd_q];

endmodule

// File: rtl/deflect_ejector.sv
// rtl/deflect_ejector.sv - removes at most one locally addressed flit per cycle into an ejection FIFO
module deflect_ejector
  import router_pkg::*;
#(
  parameter int LOCAL_ROW  = 4,
  parameter int LOCAL_COL  = 4,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DW+6:0]                 north_in,
  input  logic [DW+6:0]                 south_in,
  input  logic [DW+6:0]                 east_in,
  input  logic [DW+6:0]                 west_in,
  output logic [DW+6:0]                 north_out,
  output logic [DW+6:0]                 south_out,
  output logic [DW+6:0]                 east_out,
  output logic [DW+6:0]                 west_out,
  output logic [DW+5:0]                 ej_flit,
  output logic                          ej_valid,
  input  logic                          ej_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ej_count
);

  localparam logic [ADDR_W-1:0] LOCAL_ADDR = {LOCAL_ROW[2:0], LOCAL_COL[2:0]};

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     payload;
  } flit_t;

  flit_t          in_f  [NUM_PORTS];
  flit_t          out_q [NUM_PORTS];
  flit_t          out_d [NUM_PORTS];
  logic [1:0]     rr_q, rr_d, grant;
  logic [3:0]     match;
  logic           found, eject, fifo_full, fifo_empty;
  logic [DW+5:0]  push_data;

  assign in_f[PORT_N] = north_in;
  assign in_f[PORT_S] = south_in;
  assign in_f[PORT_E] = east_in;
  assign in_f[PORT_W] = west_in;

  always_comb begin
    match = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      match[p] = flit_valid({in_f[p].valid, in_f[p].addr}) && (in_f[p].addr == LOCAL_ADDR);
    end
  end

  // Round-robin scan starting at rr_q; 2-bit index arithmetic wraps modulo four.
  always_comb begin
    grant = rr_q;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && match[rr_q + 2'(i)]) begin
        grant = rr_q + 2'(i);
        found = 1'b1;
      end
    end
  end

  assign eject = found && !fifo_full;

  always_comb begin
    rr_d = eject ? grant + 2'd1 : rr_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      out_d[p] = in_f[p].valid ? in_f[p] : '0;
      if (eject && (grant == 2'(p))) out_d[p] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) out_q[p] <= '0;
    end else begin
      rr_q <= rr_d;
      for (int p = 0; p < NUM_PORTS; p++) out_q[p] <= out_d[p];
    end
  end

  assign push_data = {in_f[grant].addr, in_f[grant].payload};

  eject_fifo #(
    .W     (DW + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_eject_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (eject),
    .push_data_i (push_data),
    .pop_i       (ej_ready),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (ej_count),
    .head_o      (ej_flit)
  );

  assign ej_valid  = !fifo_empty;
  assign north_out = out_q[PORT_N];
  assign south_out = out_q[PORT_S];
  assign east_out  = out_q[PORT_E];
  assign west_out  = out_q[PORT_W];

endmodule

// File: tb/tb_deflect_ejector.sv
// tb/tb_deflect_ejector.sv - scoreboard bench for deflect_ejector against a queue-based reference model
module tb_deflect_ejector;

  localparam int DEPTH = 4;
  localparam logic [5:0] LOC = 6'o44;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [22:0] in_v [4];
  logic [22:0] north_out, south_out, east_out, west_out;
  logic [21:0] ej_flit;
  logic        ej_valid;
  logic        ej_ready;
  logic [2:0]  ej_count;

  always #5 clk = ~clk;

  deflect_ejector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .north_in  (in_v[0]),
    .south_in  (in_v[1]),
    .east_in   (in_v[2]),
    .west_in   (in_v[3]),
    .north_out (north_out),
    .south_out (south_out),
    .east_out  (east_out),
    .west_out  (west_out),
    .ej_flit   (ej_flit),
    .ej_valid  (ej_valid),
    .ej_ready  (ej_ready),
    .ej_count  (ej_count)
  );

  typedef struct packed {
    logic [3:0][22:0] outs;
    logic             v;
    logic [21:0]      flit;
    logic [2:0]       cnt;
  } exp_t;

  exp_t        exp_q [$];
  logic [21:0] m_q [$];
  int          m_rr;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [22:0] mk(input logic v, input logic [5:0] a, input logic [15:0] pl);
    return {v, a, pl};
  endfunction

  // Reference: eject the first local flit found scanning from the rotating start,
  // unless the queue already holds DEPTH entries; pops see the pre-edge occupancy.
  task automatic step(input logic [3:0][22:0] f, input logic rdy);
    exp_t e;
    int   g;
    bit   full, pop;
    @(negedge clk);
    for (int p = 0; p < 4; p++) in_v[p] = f[p];
    ej_ready = rdy;
    full = (m_q.size() >= DEPTH);
    pop  = (m_q.size() > 0) && rdy;
    g = -1;
    if (!full) begin
      for (int k = 0; k < 4; k++) begin
        int p;
        p = (m_rr + k) % 4;
        if (g < 0 && f[p][22] && f[p][21:16] == LOC) g = p;
      end
    end
    for (int p = 0; p < 4; p++) e.outs[p] = (f[p][22] && p != g) ? f[p] : 23'd0;
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(f[g][21:0]);
      m_rr = (g + 1) % 4;
    end
    e.v    = (m_q.size() > 0);
    e.flit = (m_q.size() > 0) ? m_q[0] : 22'd0;
    e.cnt  = 3'(m_q.size());
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    cmp({tag, "_north"}, 32'(north_out), 32'd0);
    cmp({tag, "_south"}, 32'(south_out), 32'd0);
    cmp({tag, "_east"},  32'(east_out),  32'd0);
    cmp({tag, "_west"},  32'(west_out),  32'd0);
    cmp({tag, "_valid"}, 32'(ej_valid),  32'd0);
    cmp({tag, "_flit"},  32'(ej_flit),   32'd0);
    cmp({tag, "_count"}, 32'(ej_count),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    for (int p = 0; p < 4; p++) in_v[p] = '0;
    ej_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle("rst_async");
    @(posedge clk);
    #1 check_idle("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    m_q.delete();
    m_rr = 0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("north_out", 32'(north_out), 32'(e.outs[0]));
        cmp("south_out", 32'(south_out), 32'(e.outs[1]));
        cmp("east_out",  32'(east_out),  32'(e.outs[2]));
        cmp("west_out",  32'(west_out),  32'(e.outs[3]));
        cmp("ej_valid",  32'(ej_valid),  32'(e.v));
        cmp("ej_flit",   32'(ej_flit),   32'(e.flit));
        cmp("ej_count",  32'(ej_count),  32'(e.cnt));
      end
    end
  end

  initial begin
    logic [3:0][22:0] f;
    int               wait_cyc;
    rst_n = 1'b0;
    ej_ready = 1'b0;
    for (int p = 0; p < 4; p++) in_v[p] = '0;
    m_rr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_idle("reset");

    // two pushes, then reset mid-stream
    f = '0; f[0] = mk(1, LOC, 16'h0001); step(f, 0);
    f = '0; f[1] = mk(1, LOC, 16'h0002); step(f, 0);
    do_reset();

    // single local flit on east
    f = '0; f[2] = mk(1, LOC, 16'hBEEF); step(f, 0);
    f = '0; step(f, 0);
    do_reset();

    // all four local for four cycles: grants rotate N,S,E,W
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 4; p++) f[p] = mk(1, LOC, 16'(16'h1000 + c * 16 + p));
      step(f, 0);
    end
    // full FIFO: no eject even with a pop, then the retried flit is taken
    f = '0; f[0] = mk(1, LOC, 16'hAAAA);
    step(f, 1);
    step(f, 1);
    do_reset();

    // non-local traffic only; a following all-local cycle must grant north
    for (int c = 0; c < 10; c++) begin
      for (int p = 0; p < 4; p++) f[p] = mk(1, 6'o12, 16'($urandom));
      step(f, 1'($urandom));
    end
    for (int p = 0; p < 4; p++) f[p] = mk(1, LOC, 16'(16'h2000 + p));
    step(f, 0);
    do_reset();

    // streaming one local flit per cycle with the core always ready
    for (int c = 0; c < 20; c++) begin
      f = '0;
      f[$urandom_range(0, 3)] = mk(1, LOC, 16'(16'h3000 + c));
      step(f, 1);
    end

    // randomized mix, including invalid flits with junk addr/payload bits
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 4; p++) begin
        logic [5:0] a;
        a = ($urandom_range(0, 9) < 4) ? LOC : 6'($urandom);
        f[p] = mk(($urandom_range(0, 1) == 1), a, 16'($urandom));
      end
      step(f, ($urandom_range(0, 9) < 6));
    end
    f = '0;
    for (int c = 0; c < 6; c++) step(f, 1);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
